// File: rtl/cpu_pkg.sv
// Shared defaults and types for the register writeback path.
// Holds default widths, queue depth and the queued {addr,data} entry.
package cpu_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NUM_CH_DEF = 2;
   localparam int DEPTH_DEF  = 4;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
   } wb_entry_t;

   // Index width for a one-or-more element set.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/writeback_buffer_queue.sv
// wb_queue: circular FIFO of {addr,data} entries with age-ordered read-out.
// Ports: clk, reset (async low), push/din, pop, count, ents (oldest in LSBs).
module wb_queue
   import cpu_pkg::*;
#(
   parameter int W     = ADDR_W_DEF + DATA_W_DEF,
   parameter int DEPTH = DEPTH_DEF
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic [W-1:0]            din,
   input  logic                    pop,
   output logic [$clog2(DEPTH):0]  count,
   output logic [DEPTH*W-1:0]      ents
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push)
            tail <= tail + PW'(1);
         if (pop)
            head <= head + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[tail] <= din;
   end

   // Slot i of ents is the i-th oldest entry; only the first count are live.
   always_comb begin
      ents = '0;
      for (int i = 0; i < DEPTH; i++)
         ents[i*W +: W] = mem[head + PW'(i)];
   end

endmodule

// File: rtl/writeback_buffer.sv
// Register file with a queued, round-robin arbitrated multi-channel write port.
// Ports: clk, reset, in_valid/in_ready/in_addr/in_data, ra1/ra2->rd1/rd2, wr, count.
module writeback_buffer
   import cpu_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_CH   = NUM_CH_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int ZERO_REG = 1
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        in_valid,
   output logic [NUM_CH-1:0]        in_ready,
   input  logic [NUM_CH*ADDR_W-1:0] in_addr,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [ADDR_W-1:0]        ra1,
   input  logic [ADDR_W-1:0]        ra2,
   output logic [DATA_W-1:0]        rd1,
   output logic [DATA_W-1:0]        rd2,
   output logic                     wr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int CW   = $clog2(DEPTH) + 1;
   localparam int EW   = ADDR_W + DATA_W;
   localparam int GW   = ptr_w(NUM_CH);
   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NREG];
   logic [GW-1:0]     rr_ptr;
   logic [GW-1:0]     gnt_idx;
   logic [NUM_CH-1:0] gnt;
   logic              hs;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic [CW-1:0]     count_nx;
   logic [DEPTH*EW-1:0] ents;

   function automatic logic [GW-1:0] ch_at(input logic [GW-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= NUM_CH)
         s = s - NUM_CH;
      return GW'(s);
   endfunction

   // Scan from the far end so the channel closest to rr_ptr wins.
   always_comb begin
      hs      = 1'b0;
      gnt_idx = '0;
      gnt     = '0;
      if (count != CW'(DEPTH)) begin
         for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (in_valid[ch_at(rr_ptr, k)]) begin
               hs      = 1'b1;
               gnt_idx = ch_at(rr_ptr, k);
            end
         end
      end
      if (hs)
         gnt[gnt_idx] = 1'b1;
   end

   assign in_ready = gnt & {NUM_CH{reset}};
   assign sel_addr = in_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
   assign sel_data = in_data[int'(gnt_idx)*DATA_W +: DATA_W];

   // Writes to a hardwired zero register are granted but dropped.
   assign push     = hs && !(ZERO_REG != 0 && sel_addr == '0);
   assign pop      = (count != '0);
   assign count_nx = count + CW'(push) - CW'(pop);

   wb_queue #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   ({sel_addr, sel_data}),
      .pop   (pop),
      .count (count),
      .ents  (ents)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
         rr_ptr <= '0;
         wr     <= 1'b1;
      end else begin
         if (pop)
            regs[ents[DATA_W +: ADDR_W]] <= ents[0 +: DATA_W];
         if (hs)
            rr_ptr <= ch_at(gnt_idx, 1);
         wr <= (count_nx == '0) && !hs;
      end
   end

   // Later queue slots are younger, so the last match wins.
   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] v;
      assign a = (p == 0) ? ra1 : ra2;
      always_comb begin
         v = regs[a];
         for (int i = 0; i < DEPTH; i++)
            if (CW'(i) < count && ents[i*EW+DATA_W +: ADDR_W] == a)
               v = ents[i*EW +: DATA_W];
         if (ZERO_REG != 0 && a == '0)
            v = '0;
      end
   end

   assign rd1 = g_rd[0].v;
   assign rd2 = g_rd[1].v;

endmodule
